// File: rtl/bp_be_pkg.sv
// Shared backend types: RV64 register widths and the integer forwarding entry.
package bp_be_pkg;

  localparam int unsigned rv64_reg_addr_width_gp = 5;
  localparam int unsigned rv64_reg_data_width_gp = 64;

  typedef struct packed {
    logic                              v;
    logic                              w_v;
    logic                              data_v;
    logic [rv64_reg_addr_width_gp-1:0] addr;
    logic [rv64_reg_data_width_gp-1:0] data;
  } bp_be_int_fwd_entry_s;

endpackage

// File: rtl/bp_be_int_hazard_detect.sv
// Youngest-match scan for one source register: flags a hazard when the youngest
// in-flight writer of rs has not produced its data yet.
module bp_be_int_hazard_detect
  import bp_be_pkg::*;
#(
  parameter int unsigned els_p = 4
) (
  input  logic [rv64_reg_addr_width_gp-1:0]            rs_addr_i,
  input  logic [els_p-1:0][rv64_reg_addr_width_gp-1:0] addr_i,
  input  logic [els_p-1:0]                             vw_i,
  input  logic [els_p-1:0]                             data_v_i,
  output logic                                         hazard_o
);

  logic [els_p-1:0] match;
  logic [els_p-1:0] youngest;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      match[i] = vw_i[i] & (addr_i[i] == rs_addr_i) & (rs_addr_i != '0);
    end
    // Lowest set bit wins: index 0 is the youngest entry.
    youngest = match & ~(match - els_p'(1));
    hazard_o = |(youngest & ~data_v_i);
  end

endmodule

// File: rtl/bp_be_int_result_pipe.sv
// Integer result pipeline feeding the bypass network and the register-file
// write port; merges late (mul/load) results at late_stage_p.
module bp_be_int_result_pipe
  import bp_be_pkg::*;
#(
  parameter int unsigned fwd_els_p = 4,
  parameter int unsigned late_stage_p = 2,
  localparam int unsigned reg_addr_width_lp = rv64_reg_addr_width_gp,
  localparam int unsigned reg_data_width_lp = rv64_reg_data_width_gp
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic                                           issue_v_i,
  input  logic                                           issue_rd_w_v_i,
  input  logic [reg_addr_width_lp-1:0]                   issue_rd_addr_i,
  input  logic                                           issue_data_v_i,
  input  logic [reg_data_width_lp-1:0]                   issue_data_i,
  input  logic                                           late_v_i,
  input  logic [reg_data_width_lp-1:0]                   late_data_i,
  input  logic                                           stall_i,
  input  logic [fwd_els_p-1:0]                           kill_i,
  input  logic [reg_addr_width_lp-1:0]                   rs1_addr_i,
  input  logic [reg_addr_width_lp-1:0]                   rs2_addr_i,
  output logic                                           hazard_o,
  output logic [fwd_els_p-1:0]                           fwd_rd_v_o,
  output logic [fwd_els_p-1:0][reg_addr_width_lp-1:0]    fwd_rd_addr_o,
  output logic [fwd_els_p-1:0][reg_data_width_lp-1:0]    fwd_rd_o,
  output logic                                           wb_v_o,
  output logic [reg_addr_width_lp-1:0]                   wb_addr_o,
  output logic [reg_data_width_lp-1:0]                   wb_data_o,
  output logic                                           late_err_o
);

  // Position a late entry occupies after advancing; absent if late_stage_p is last.
  localparam bit          late_adv_ok_lp = (late_stage_p + 1) < fwd_els_p;
  localparam int unsigned late_adv_lp    = late_adv_ok_lp ? late_stage_p + 1 : fwd_els_p - 1;

  bp_be_int_fwd_entry_s [fwd_els_p-1:0] stage_q, stage_d;
  logic                                 late_err_q, late_err_d;

  logic                                 late_pend, late_merge, late_orphan;
  logic [fwd_els_p-1:0]                 vw, data_v;
  logic                                 hazard_rs1, hazard_rs2;

  always_comb begin
    late_pend   = stage_q[late_stage_p].v & stage_q[late_stage_p].w_v &
                  ~stage_q[late_stage_p].data_v & ~kill_i[late_stage_p];
    late_merge  = late_v_i & late_pend;
    late_orphan = ~stall_i & late_pend & ~late_v_i;
    late_err_d  = (late_v_i & ~late_pend) | late_orphan;

    stage_d = stage_q;
    if (stall_i) begin
      for (int unsigned i = 0; i < fwd_els_p; i++) begin
        stage_d[i].v = stage_q[i].v & ~kill_i[i];
      end
      if (late_merge) begin
        stage_d[late_stage_p].data_v = 1'b1;
        stage_d[late_stage_p].data   = late_data_i;
      end
    end else begin
      stage_d[0].v      = issue_v_i;
      stage_d[0].w_v    = issue_rd_w_v_i & (issue_rd_addr_i != '0);
      stage_d[0].data_v = issue_data_v_i;
      stage_d[0].addr   = issue_rd_addr_i;
      stage_d[0].data   = issue_data_i;
      for (int unsigned i = 1; i < fwd_els_p; i++) begin
        stage_d[i]   = stage_q[i-1];
        stage_d[i].v = stage_q[i-1].v & ~kill_i[i-1];
      end
      if (late_adv_ok_lp) begin
        if (late_merge) begin
          stage_d[late_adv_lp].data_v = 1'b1;
          stage_d[late_adv_lp].data   = late_data_i;
        end
        // A late result that never showed up must not write back stale data.
        if (late_orphan) begin
          stage_d[late_adv_lp].w_v = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_q    <= '0;
      late_err_q <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      late_err_q <= late_err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < fwd_els_p; i++) begin
      vw[i]            = stage_q[i].v & stage_q[i].w_v;
      data_v[i]        = stage_q[i].data_v;
      fwd_rd_v_o[i]    = stage_q[i].v & stage_q[i].w_v & stage_q[i].data_v;
      fwd_rd_addr_o[i] = stage_q[i].addr;
      fwd_rd_o[i]      = stage_q[i].data;
    end
    wb_v_o     = fwd_rd_v_o[fwd_els_p-1] & ~stall_i & ~kill_i[fwd_els_p-1];
    wb_addr_o  = stage_q[fwd_els_p-1].addr;
    wb_data_o  = stage_q[fwd_els_p-1].data;
    late_err_o = late_err_q;
    hazard_o   = hazard_rs1 | hazard_rs2;
  end

  bp_be_int_hazard_detect #(
    .els_p(fwd_els_p)
  ) u_hazard_rs1 (
    .rs_addr_i(rs1_addr_i),
    .addr_i   (fwd_rd_addr_o),
    .vw_i     (vw),
    .data_v_i (data_v),
    .hazard_o (hazard_rs1)
  );

  bp_be_int_hazard_detect #(
    .els_p(fwd_els_p)
  ) u_hazard_rs2 (
    .rs_addr_i(rs2_addr_i),
    .addr_i   (fwd_rd_addr_o),
    .vw_i     (vw),
    .data_v_i (data_v),
    .hazard_o (hazard_rs2)
  );

endmodule
